// File: rtl/sc1602_responder.sv
// sc1602_responder: HD44780-compatible target for the SC1602 8-bit EN/RS/RW/DATA bus
// Ports:
//   clk, resetn              system clock, asynchronous active-low reset
//   sc1602_en/rs/rw/data_in  bus from the LCD driver; transactions execute on EN fall
//   sc1602_data_out/_oe      read data ({busy, ac} or DDRAM[AC]) and its drive enable
//   rd_addr, rd_data         registered DDRAM observation port (HD44780 addressing)
//   busy, ac                 busy flag and address counter
//   disp_ctrl, entry_mode    {D, C, B} and {I/D, S}
//   func_set                 {DL, N, F}
//   cmd_err, busy_viol       one-cycle pulses: unsupported instruction, dropped transaction
module sc1602_responder #(
    parameter int BUSY_SHORT = 1,
    parameter int BUSY_LONG  = 42
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sc1602_en,
    input  logic       sc1602_rs,
    input  logic       sc1602_rw,
    input  logic [7:0] sc1602_data_in,
    output logic [7:0] sc1602_data_out,
    output logic       sc1602_data_oe,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic [6:0] ac,
    output logic [2:0] disp_ctrl,
    output logic [1:0] entry_mode,
    output logic [2:0] func_set,
    output logic       cmd_err,
    output logic       busy_viol
);
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] SHORT = 8'(BUSY_SHORT);
    localparam logic [7:0] LONG  = 8'(BUSY_LONG);

    logic [7:0] line1 [0:39];
    logic [7:0] line2 [0:39];
    logic       en_q, sh_rs, sh_rw;
    logic [7:0] sh_data;
    logic [7:0] busy_cnt;
    logic       clr_act;
    logic [5:0] clr_idx;
    logic [7:0] dout_q;
    logic       fall, exec, drop, data_wr, data_rd, instr;
    logic [7:0] ac_byte;
    logic [6:0] ac_next;

    assign busy    = busy_cnt != 8'd0;
    assign fall    = en_q & ~sc1602_en;
    assign exec    = fall & ~busy;
    // status reads are exempt from the busy rule; they change no state anyway
    assign drop    = fall & busy & ~(~sh_rs & sh_rw);
    assign data_wr = exec & sh_rs & ~sh_rw;
    assign data_rd = exec & sh_rs & sh_rw;
    assign instr   = exec & ~sh_rs & ~sh_rw;

    assign ac_byte = ac[6] ? line2[ac[5:0]] : line1[ac[5:0]];
    // AC walks only the valid windows: line 1 end joins line 2 start and vice versa
    assign ac_next = entry_mode[1]
        ? ((ac == 7'h27) ? 7'h40 : (ac == 7'h67) ? 7'h00 : ac + 7'd1)
        : ((ac == 7'h00) ? 7'h67 : (ac == 7'h40) ? 7'h27 : ac - 7'd1);

    assign sc1602_data_oe  = sc1602_en & sc1602_rw;
    assign sc1602_data_out = sc1602_en ? (sc1602_rs ? ac_byte : {busy, ac}) : dout_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en_q       <= 1'b0;
            sh_rs      <= 1'b0;
            sh_rw      <= 1'b0;
            sh_data    <= 8'h00;
            busy_cnt   <= LONG;
            clr_act    <= 1'b1;
            clr_idx    <= 6'd0;
            ac         <= 7'h00;
            disp_ctrl  <= 3'b000;
            entry_mode <= 2'b10;
            func_set   <= 3'b100;
            cmd_err    <= 1'b0;
            busy_viol  <= 1'b0;
            dout_q     <= 8'h00;
        end else begin
            en_q      <= sc1602_en;
            cmd_err   <= 1'b0;
            busy_viol <= drop;
            if (sc1602_en) begin
                sh_rs   <= sc1602_rs;
                sh_rw   <= sc1602_rw;
                sh_data <= sc1602_data_in;
                dout_q  <= sc1602_data_out;
            end
            if (busy)
                busy_cnt <= busy_cnt - 8'd1;
            if (clr_act) begin
                clr_idx <= clr_idx + 6'd1;
                clr_act <= clr_idx != 6'd39;
            end
            if (data_wr | data_rd) begin
                ac       <= ac_next;
                busy_cnt <= SHORT;
            end
            if (instr) begin
                if (sh_data[7]) begin
                    if (sh_data[5:0] <= 6'd39) begin
                        ac       <= sh_data[6:0];
                        busy_cnt <= SHORT;
                    end else
                        cmd_err <= 1'b1;
                end else if (sh_data[6])
                    cmd_err <= 1'b1;
                else if (sh_data[5]) begin
                    func_set <= sh_data[4:2];
                    busy_cnt <= SHORT;
                end else if (sh_data[4])
                    cmd_err <= 1'b1;
                else if (sh_data[3]) begin
                    disp_ctrl <= sh_data[2:0];
                    busy_cnt  <= SHORT;
                end else if (sh_data[2]) begin
                    entry_mode <= sh_data[1:0];
                    busy_cnt   <= SHORT;
                end else if (sh_data[1]) begin
                    ac       <= 7'h00;
                    busy_cnt <= LONG;
                end else if (sh_data[0]) begin
                    ac            <= 7'h00;
                    entry_mode[1] <= 1'b1;
                    busy_cnt      <= LONG;
                    clr_act       <= 1'b1;
                    clr_idx       <= 6'd0;
                end
            end
        end
    end

    // both banks are filled in parallel; bus writes cannot overlap a fill since it runs under busy
    always_ff @(posedge clk) begin
        if (clr_act) begin
            line1[clr_idx] <= SPACE;
            line2[clr_idx] <= SPACE;
        end else if (data_wr) begin
            if (ac[6])
                line2[ac[5:0]] <= sh_data;
            else
                line1[ac[5:0]] <= sh_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            rd_data <= 8'h00;
        else
            rd_data <= (rd_addr[5:0] > 6'd39) ? SPACE
                     : rd_addr[6] ? line2[rd_addr[5:0]] : line1[rd_addr[5:0]];
    end
endmodule

// File: tb/tb_sc1602_responder.sv
// tb_sc1602_responder: directed scoreboard bench for sc1602_responder
module tb_sc1602_responder;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       sc1602_en = 1'b0;
    logic       sc1602_rs = 1'b0;
    logic       sc1602_rw = 1'b0;
    logic [7:0] sc1602_data_in = 8'h00;
    logic [7:0] sc1602_data_out;
    logic       sc1602_data_oe;
    logic [6:0] rd_addr = 7'h00;
    logic [7:0] rd_data;
    logic       busy;
    logic [6:0] ac;
    logic [2:0] disp_ctrl;
    logic [1:0] entry_mode;
    logic [2:0] func_set;
    logic       cmd_err;
    logic       busy_viol;

    always #5 clk = ~clk;

    sc1602_responder dut (
        .clk(clk), .resetn(resetn),
        .sc1602_en(sc1602_en), .sc1602_rs(sc1602_rs), .sc1602_rw(sc1602_rw),
        .sc1602_data_in(sc1602_data_in), .sc1602_data_out(sc1602_data_out),
        .sc1602_data_oe(sc1602_data_oe), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .ac(ac), .disp_ctrl(disp_ctrl), .entry_mode(entry_mode),
        .func_set(func_set), .cmd_err(cmd_err), .busy_viol(busy_viol)
    );

    typedef enum int {K_AC, K_BUSY, K_FUNC, K_DISP, K_ENTRY, K_RD, K_DOUT, K_ERRS, K_VIOLS, K_BLEN} kind_t;
    typedef struct { kind_t kind; int exp; } item_t;

    item_t sb[$];
    item_t it;
    int    act;
    int    n_cmp = 0, n_bad = 0;
    int    run = 0, last_run = 0, err_seen = 0, viol_seen = 0;
    int    exp_err = 0, exp_viol = 0;

    function automatic int actual(kind_t k);
        case (k)
            K_AC:    return int'(ac);
            K_BUSY:  return int'(busy);
            K_FUNC:  return int'(func_set);
            K_DISP:  return int'(disp_ctrl);
            K_ENTRY: return int'(entry_mode);
            K_RD:    return int'(rd_data);
            K_DOUT:  return int'(sc1602_data_out);
            K_ERRS:  return err_seen;
            K_VIOLS: return viol_seen;
            default: return last_run;
        endcase
    endfunction

    // monitor: tracks busy run lengths and pulse counts, then drains the scoreboard
    always @(negedge clk) begin
        if (!resetn)
            run = 0;
        else if (busy)
            run++;
        else if (run != 0) begin
            last_run = run;
            run = 0;
        end
        if (cmd_err)   err_seen++;
        if (busy_viol) viol_seen++;
        while (sb.size() > 0) begin
            it  = sb.pop_front();
            act = actual(it.kind);
            n_cmp++;
            if (act != it.exp) begin
                n_bad++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", it.kind.name(), act, it.exp);
            end
        end
    end

    task automatic push(input kind_t k, input int e);
        item_t x;
        x.kind = k;
        x.exp  = e;
        sb.push_back(x);
    endtask

    task automatic op(input logic rs, input logic rw, input logic [7:0] d, input int idle);
        sc1602_rs = rs;
        sc1602_rw = rw;
        sc1602_data_in = d;
        sc1602_en = 1'b1;
        @(posedge clk); #1 sc1602_en = 1'b0;
        @(posedge clk); #1;
        repeat (idle) begin @(posedge clk); #1; end
    endtask

    task automatic op_rd(input logic rs, input int e, input int idle);
        sc1602_rs = rs;
        sc1602_rw = 1'b1;
        sc1602_en = 1'b1;
        push(K_DOUT, e);
        @(posedge clk); #1 sc1602_en = 1'b0;
        @(posedge clk); #1;
        repeat (idle) begin @(posedge clk); #1; end
    endtask

    task automatic check_rd(input logic [6:0] a, input int e);
        rd_addr = a;
        @(posedge clk); #1;
        push(K_RD, e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        string s;
        s = "0123456789ABCDEF";
        // reset values
        wait_cyc(3);
        push(K_AC, 0); push(K_DISP, 0); push(K_ENTRY, 2); push(K_FUNC, 4);
        push(K_RD, 0); push(K_ERRS, 0); push(K_VIOLS, 0);
        wait_cyc(1);
        resetn = 1'b1;
        // automatic clear after reset
        wait_cyc(50);
        push(K_BLEN, 42); push(K_BUSY, 0); push(K_AC, 0); push(K_FUNC, 4);
        check_rd(7'h00, 8'h20); check_rd(7'h27, 8'h20);
        check_rd(7'h40, 8'h20); check_rd(7'h67, 8'h20);
        // init sequence with driver spacing
        op(0, 0, 8'h38, 1); op(0, 0, 8'h08, 1); op(0, 0, 8'h01, 43);
        op(0, 0, 8'h0C, 1); op(0, 0, 8'h06, 1); op(0, 0, 8'h02, 43);
        push(K_FUNC, 6); push(K_DISP, 4); push(K_ENTRY, 2); push(K_AC, 0);
        push(K_ERRS, 0); push(K_VIOLS, 0);
        // write a string, jump to line 2
        op(0, 0, 8'h80, 1);
        for (int i = 0; i < 16; i++) op(1, 0, s[i], 2);
        push(K_AC, 'h10);
        wait_cyc(3);
        push(K_BLEN, 1);
        op(0, 0, 8'hC0, 1); op(1, 0, "X", 2);
        push(K_AC, 'h41);
        check_rd(7'h0F, "F"); check_rd(7'h40, "X"); check_rd(7'h00, "0");
        // AC wraps in both directions
        op(0, 0, 8'hA7, 1); op(1, 0, "a", 2);
        push(K_AC, 'h40);
        check_rd(7'h27, "a");
        op(0, 0, 8'hE7, 1); op(1, 0, "b", 2);
        push(K_AC, 'h00);
        check_rd(7'h67, "b");
        op(0, 0, 8'h04, 1);
        push(K_ENTRY, 0);
        op(0, 0, 8'hC0, 1); op(1, 0, "c", 2);
        push(K_AC, 'h27);
        check_rd(7'h40, "c");
        op(0, 0, 8'h80, 1); op(1, 0, "e", 2);
        push(K_AC, 'h67);
        check_rd(7'h00, "e");
        op(0, 0, 8'h06, 1);
        // data read returns DDRAM[AC] and steps AC
        op(0, 0, 8'h80, 1);
        op_rd(1, "e", 2);
        push(K_AC, 1);
        check_rd(7'h28, 8'h20); check_rd(7'h7F, 8'h20);
        // busy violation 5 cycles after a clear, status read inside the window
        op(0, 0, 8'h01, 3);
        op(1, 0, "Z", 1);
        exp_viol++;
        op_rd(0, 'h80, 2);
        wait_cyc(40);
        push(K_VIOLS, exp_viol); push(K_AC, 0); push(K_BUSY, 0);
        check_rd(7'h00, 8'h20); check_rd(7'h0F, 8'h20);
        // fall on the last busy cycle is dropped, the next cycle is accepted
        op(0, 0, 8'h01, 40);
        op(1, 0, "P", 2);
        exp_viol++;
        push(K_VIOLS, exp_viol); push(K_AC, 0); push(K_BLEN, 42);
        check_rd(7'h00, 8'h20);
        op(0, 0, 8'h01, 41);
        op(1, 0, "Q", 2);
        push(K_AC, 1); push(K_VIOLS, exp_viol);
        check_rd(7'h00, "Q");
        push(K_BLEN, 1);
        // unsupported instructions
        op(0, 0, 8'h85, 1);
        op(0, 0, 8'h40, 1); exp_err++;
        push(K_AC, 5); push(K_ERRS, exp_err);
        op(0, 0, 8'hA8, 1); exp_err++;
        push(K_AC, 5); push(K_ERRS, exp_err);
        op(0, 0, 8'hE8, 1); exp_err++;
        op(0, 0, 8'h10, 1); exp_err++;
        push(K_AC, 5); push(K_ERRS, exp_err); push(K_VIOLS, exp_viol);
        // reset in the middle of a clear restarts the full busy window
        op(0, 0, 8'h01, 0);
        wait_cyc(10);
        resetn = 1'b0;
        check_rd(7'h05, 0);
        push(K_DISP, 0); push(K_FUNC, 4);
        wait_cyc(1);
        resetn = 1'b1;
        wait_cyc(50);
        push(K_BLEN, 42); push(K_BUSY, 0); push(K_AC, 0); push(K_ENTRY, 2);
        check_rd(7'h05, 8'h20);
        push(K_ERRS, exp_err); push(K_VIOLS, exp_viol);
        wait_cyc(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
